// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : fifo_wr_arbiter                                             |
// | Purpose  : Round-robin arbiter serialising ALU words / RF bytes to FIFO |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module fifo_wr_arbiter #(
    parameter int DW = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            alu_vld,
    input  logic [2*DW-1:0] alu_data,
    output logic            alu_ack,
    input  logic            rf_vld,
    input  logic [DW-1:0]   rf_data,
    output logic            rf_ack,
    input  logic            wfull,
    output logic [DW-1:0]   wdata,
    output logic            winc,
    output logic            busy
);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_WR_LO   = 2'd1;
    localparam logic [1:0] C_WR_HI   = 2'd2;
    localparam logic [1:0] C_WR_BYTE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [2*DW-1:0] r_hold;
    logic            r_last_rf;
    logic            r_alu_ack;
    logic            r_rf_ack;
    logic            w_grant_alu;
    logic            w_grant_rf;
    logic            w_winc;
    logic [DW-1:0]   w_wdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_alu = 1'b0;
        w_grant_rf  = 1'b0;
        w_winc      = (r_state != C_IDLE) && !wfull;
        w_wdata     = '0;
        case (r_state)
            C_IDLE: begin
                // On contention the requester not served last wins.
                if (alu_vld && (!rf_vld || r_last_rf)) begin
                    w_grant_alu = 1'b1;
                    w_state_nxt = C_WR_LO;
                end else if (rf_vld) begin
                    w_grant_rf  = 1'b1;
                    w_state_nxt = C_WR_BYTE;
                end
            end
            C_WR_LO: begin
                w_wdata = r_hold[DW-1:0];
                if (w_winc) w_state_nxt = C_WR_HI;
            end
            C_WR_HI: begin
                w_wdata = r_hold[2*DW-1:DW];
                if (w_winc) w_state_nxt = C_IDLE;
            end
            C_WR_BYTE: begin
                w_wdata = r_hold[DW-1:0];
                if (w_winc) w_state_nxt = C_IDLE;
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold    <= '0;
            r_last_rf <= 1'b1;
            r_alu_ack <= 1'b0;
            r_rf_ack  <= 1'b0;
        end else begin
            r_alu_ack <= w_grant_alu;
            r_rf_ack  <= w_grant_rf;
            if (w_grant_alu) begin
                r_hold    <= alu_data;
                r_last_rf <= 1'b0;
            end else if (w_grant_rf) begin
                r_hold[DW-1:0] <= rf_data;
                r_last_rf      <= 1'b1;
            end
        end
    end

    assign alu_ack = r_alu_ack;
    assign rf_ack  = r_rf_ack;
    assign winc    = w_winc;
    assign wdata   = w_wdata;
    assign busy    = (r_state != C_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : tb_fifo_wr_arbiter                                          |
// | Purpose  : Directed self-checking bench for fifo_wr_arbiter            |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

    localparam int DW = 8;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            alu_vld = 1'b0;
    logic [2*DW-1:0] alu_data = '0;
    logic            alu_ack;
    logic            rf_vld = 1'b0;
    logic [DW-1:0]   rf_data = '0;
    logic            rf_ack;
    logic            wfull = 1'b0;
    logic [DW-1:0]   wdata;
    logic            winc;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_wr_arbiter #(.DW(DW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .alu_vld  (alu_vld),
        .alu_data (alu_data),
        .alu_ack  (alu_ack),
        .rf_vld   (rf_vld),
        .rf_data  (rf_data),
        .rf_ack   (rf_ack),
        .wfull    (wfull),
        .wdata    (wdata),
        .winc     (winc),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic w, input logic [7:0] d,
                           input logic b, input logic aa, input logic ra);
        chk({tag, ".winc"},    {15'd0, winc},    {15'd0, w});
        chk({tag, ".wdata"},   {8'd0, wdata},    {8'd0, d});
        chk({tag, ".busy"},    {15'd0, busy},    {15'd0, b});
        chk({tag, ".alu_ack"}, {15'd0, alu_ack}, {15'd0, aa});
        chk({tag, ".rf_ack"},  {15'd0, rf_ack},  {15'd0, ra});
    endtask

    // Protocol invariants sampled mid-cycle throughout the run.
    logic prev_alu_ack = 1'b0;
    logic prev_rf_ack  = 1'b0;
    always @(negedge CLK) begin
        chk("inv.winc_while_full", {15'd0, winc & wfull}, 16'd0);
        chk("inv.both_acks",       {15'd0, alu_ack & rf_ack}, 16'd0);
        chk("inv.alu_ack_pulse",   {15'd0, alu_ack & prev_alu_ack}, 16'd0);
        chk("inv.rf_ack_pulse",    {15'd0, rf_ack & prev_rf_ack}, 16'd0);
        prev_alu_ack = alu_ack;
        prev_rf_ack  = rf_ack;
    end

    logic       exp_w  [10] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1};
    logic [7:0] exp_d  [10] = '{8'h00, 8'h34, 8'h12, 8'h00, 8'h77, 8'h00, 8'h34, 8'h12, 8'h00, 8'h77};
    logic       exp_b  [10] = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 1};
    logic       exp_aa [10] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    logic       exp_ra [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        // Reset state
        tick();
        chk_out("rst0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        #1;
        chk_out("rst1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // ALU only: A55A -> 5A, A5
        alu_vld = 1'b1; alu_data = 16'hA55A;
        tick();
        chk_out("alu.c1", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        alu_vld = 1'b0;
        tick();
        chk_out("alu.c2", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("alu.c3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // RF only: 3C
        rf_vld = 1'b1; rf_data = 8'h3C;
        tick();
        chk_out("rf.c1", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        rf_vld = 1'b0;
        tick();
        chk_out("rf.c2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Both requesters held high from reset: alternating grants
        RST = 1'b1;
        alu_vld = 1'b1; alu_data = 16'h1234;
        rf_vld  = 1'b1; rf_data  = 8'h77;
        tick();
        tick();
        RST = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("rr.c%0d", i), {busy, alu_ack, rf_ack, winc, 4'd0, wdata},
                {exp_b[i], exp_aa[i], exp_ra[i], exp_w[i], 4'd0, exp_d[i]});
            if (i < 9) begin
                tick();
            end
        end
        alu_vld = 1'b0; rf_vld = 1'b0;
        tick();
        chk_out("rr.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Stall in WR_HI for 5 cycles
        alu_vld = 1'b1; alu_data = 16'h1234;
        tick();
        chk_out("stall.lo", 1'b1, 8'h34, 1'b1, 1'b1, 1'b0);
        alu_vld = 1'b0;
        tick();
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_out($sformatf("stall.hi%0d", k), 1'b0, 8'h12, 1'b1, 1'b0, 1'b0);
            tick();
        end
        wfull = 1'b0;
        #1;
        chk_out("stall.rel", 1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("stall.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset during WR_LO, then contention goes to ALU
        alu_vld = 1'b1; alu_data = 16'hBEEF;
        tick();
        chk_out("mrst.lo", 1'b1, 8'hEF, 1'b1, 1'b1, 1'b0);
        alu_vld = 1'b0;
        RST = 1'b1;
        tick();
        chk_out("mrst.c2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        tick();
        chk_out("mrst.c3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        alu_vld = 1'b1; alu_data = 16'h5678;
        rf_vld  = 1'b1; rf_data  = 8'h99;
        tick();
        chk_out("mrst.grant", 1'b1, 8'h78, 1'b1, 1'b1, 1'b0);
        alu_vld = 1'b0; rf_vld = 1'b0;
        tick();
        chk_out("mrst.hi", 1'b1, 8'h56, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("mrst.end", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
